// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register for the pipelined MIPS core.
// Define DELAY_SLOT_EN to execute the instruction after a taken branch/jump; otherwise it is squashed.
//
// state | meaning
// BOOT  | one cycle after reset, no request issued
// FETCH | imem request outstanding at r_pc
// HELD  | word returned during a stall, parked in the one-entry buffer, no request
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_A = RESET_PC & ~32'd3;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_req;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc4;
  logic [31:0] r_target;
`ifdef DELAY_SLOT_EN
  logic        r_redir_pend;
`else
  logic        r_discard;
`endif

  logic [31:0] w_pc4;
  logic [31:0] w_redir_tgt;
  logic        w_take_redir;
  logic [31:0] w_next_pc;

  assign w_pc4        = r_pc + 32'd4;
  assign w_redir_tgt  = redirect_pc & ~32'd3;
  // A redirect only means something while decode holds a live instruction and is not held.
  assign w_take_redir = redirect && !stall && r_valid;
`ifdef DELAY_SLOT_EN
  assign w_next_pc    = r_redir_pend ? r_target : w_pc4;
`else
  assign w_next_pc    = w_pc4;
`endif

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign if_instr  = r_instr;
  assign if_pc4    = r_pc4;
  assign if_valid  = r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC_A;
      r_req        <= 1'b0;
      r_instr      <= 32'd0;
      r_pc4        <= 32'd0;
      r_valid      <= 1'b0;
      r_buf_instr  <= 32'd0;
      r_buf_pc4    <= 32'd0;
      r_target     <= 32'd0;
`ifdef DELAY_SLOT_EN
      r_redir_pend <= 1'b0;
`else
      r_discard    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end

        S_FETCH: begin
`ifndef DELAY_SLOT_EN
          // Response to a squashed fetch: drop it and restart at the saved target.
          if (imem_ack && r_discard) begin
            r_valid   <= 1'b0;
            r_pc      <= r_target;
            r_discard <= 1'b0;
          end else
`endif
          if (stall) begin
            if (imem_ack) begin
              r_buf_instr <= imem_rdata;
              r_buf_pc4   <= w_pc4;
              r_pc        <= w_next_pc;
`ifdef DELAY_SLOT_EN
              r_redir_pend <= 1'b0;
`endif
              r_state     <= S_HELD;
              r_req       <= 1'b0;
            end
          end else if (w_take_redir) begin
`ifdef DELAY_SLOT_EN
            if (imem_ack) begin
              r_instr <= imem_rdata;
              r_pc4   <= w_pc4;
              r_valid <= 1'b1;
              r_pc    <= w_redir_tgt;
            end else begin
              r_valid      <= 1'b0;
              r_target     <= w_redir_tgt;
              r_redir_pend <= 1'b1;
            end
`else
            r_valid <= 1'b0;
            if (imem_ack) begin
              r_pc <= w_redir_tgt;
            end else begin
              r_target  <= w_redir_tgt;
              r_discard <= 1'b1;
            end
`endif
          end else if (imem_ack) begin
            r_instr <= imem_rdata;
            r_pc4   <= w_pc4;
            r_valid <= 1'b1;
            r_pc    <= w_next_pc;
`ifdef DELAY_SLOT_EN
            r_redir_pend <= 1'b0;
`endif
          end else begin
            r_valid <= 1'b0;
          end
        end

        S_HELD: begin
          if (!stall) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            if (w_take_redir) begin
              // The parked word is the slot after the branch.
`ifdef DELAY_SLOT_EN
              r_instr <= r_buf_instr;
              r_pc4   <= r_buf_pc4;
              r_valid <= 1'b1;
`else
              r_valid <= 1'b0;
`endif
              r_pc    <= w_redir_tgt;
            end else begin
              r_instr <= r_buf_instr;
              r_pc4   <= r_buf_pc4;
              r_valid <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_BOOT;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected IF/ID pc4 values,
// a monitor pops and compares each delivered instruction.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;

  logic        req2;
  logic [31:0] addr2;
  logic        ack2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic [31:0] pc42;
  logic        valid2;

  int n_checks = 0;
  int n_err    = 0;
  int wait_n   = 0;
  int wcnt     = 0;
  bit sb_active = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hE5A0_0000;
  endfunction

  assign imem_ack   = imem_req && (wcnt == wait_n);
  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  assign ack2       = req2;
  assign rdata2     = mem_word(addr2);

  always @(posedge clk) begin
    if (rst) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_instr(if_instr),
    .if_pc4(if_pc4), .if_valid(if_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(32'h0), .if_instr(instr2),
    .if_pc4(pc42), .if_valid(valid2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle whose edge saw stall=0 and which shows if_valid is a fresh delivery.
  initial begin
    logic        s_rst, s_stall, s_req, s_ack;
    logic [31:0] s_addr, exp_pc4;
    logic [31:0] last_instr, last_pc4;
    logic        last_valid;
    last_instr = '0; last_pc4 = '0; last_valid = 1'b0;
    forever begin
      @(posedge clk);
      s_rst = rst; s_stall = stall; s_req = imem_req; s_ack = imem_ack; s_addr = imem_addr;
      @(negedge clk);
      if (!s_rst) begin
        if (s_req && !s_ack) begin
          chk("req_held", {31'd0, imem_req}, 32'd1);
          chk("addr_stable", imem_addr, s_addr);
        end
        if (s_stall) begin
          chk("stall_hold_valid", {31'd0, if_valid}, {31'd0, last_valid});
          chk("stall_hold_pc4", if_pc4, last_pc4);
          chk("stall_hold_instr", if_instr, last_instr);
        end else if (if_valid && sb_active) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_delivery_pc4", if_pc4, 32'hFFFF_FFFF);
          end else begin
            exp_pc4 = exp_q.pop_front();
            chk("sb_pc4", if_pc4, exp_pc4);
            chk("sb_instr", if_instr, mem_word(exp_pc4 - 32'd4));
          end
        end
      end
      last_instr = if_instr; last_pc4 = if_pc4; last_valid = if_valid;
    end
  end

  task automatic do_reset(input int w, input bit chk_rst);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    sb_active = 1'b0;
    exp_q.delete();
    wait_n = w;
    repeat (2) @(negedge clk);
    #1;
    if (chk_rst) begin
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_if_instr", if_instr, 32'd0);
      chk("rst_if_pc4", if_pc4, 32'd0);
      chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_wrap_addr", addr2, 32'hFFFF_FFFC);
    end
    rst = 1'b0;
    sb_active = 1'b1;
  endtask

  task automatic push_range(input logic [31:0] first_pc4, input logic [31:0] last_pc4);
    for (logic [31:0] p = first_pc4; p <= last_pc4; p += 32'd4) exp_q.push_back(p);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, exp_q.size(), 32'd0);
  endtask

  task automatic wait_pc4(input logic [31:0] val, input int budget);
    int  n = 0;
    bit  hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk); #1;
      n++;
      if (if_valid && if_pc4 == val) hit = 1'b1;
    end
    if (!hit) chk("wait_pc4_timeout", if_pc4, val);
  endtask

  initial begin
    logic [9:0] vpat;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // Zero-wait sequential fetch, plus wrap-around instance.
    do_reset(0, 1'b1);
    push_range(32'h4, 32'h14);
    @(negedge clk); #1;
    chk("boot_req", {31'd0, imem_req}, 32'd1);
    chk("boot_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk); #1;
    chk("lat_pc4_c2", if_pc4, 32'h4);
    chk("lat_valid_c2", {31'd0, if_valid}, 32'd1);
    chk("wrap_pc4", pc42, 32'h0);
    chk("wrap_instr", instr2, mem_word(32'hFFFF_FFFC));
    chk("wrap_addr", addr2, 32'h0);
    @(negedge clk); #1;
    chk("lat_pc4_c3", if_pc4, 32'h8);
    chk("wrap_pc4_next", pc42, 32'h4);
    @(negedge clk); #1;
    chk("lat_pc4_c4", if_pc4, 32'hC);
    wait_drain("drain_seq", 40);

    // Two wait states: one delivery every third cycle.
    do_reset(2, 1'b0);
    push_range(32'h4, 32'hC);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      vpat[i] = if_valid;
    end
    chk("wait2_valid_pattern", {22'd0, vpat}, 32'b10_0100_1000);
    wait_drain("drain_wait2", 40);

    // Stall for three cycles while 0x10 is being fetched.
    do_reset(0, 1'b0);
    push_range(32'h4, 32'h18);
    wait_pc4(32'h10, 20);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b0;
    @(negedge clk); #1;
    chk("held_release_valid", {31'd0, if_valid}, 32'd1);
    chk("held_release_pc4", if_pc4, 32'h14);
    wait_drain("drain_stall", 40);

    // Taken redirect at branch 0x20 to 0x100, zero-wait.
    do_reset(0, 1'b0);
    push_range(32'h4, 32'h24);
`ifdef DELAY_SLOT_EN
    exp_q.push_back(32'h28);
`endif
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    wait_pc4(32'h24, 30);
    redirect = 1'b1; redirect_pc = 32'h0000_0101;
    @(negedge clk);
    redirect = 1'b0;
    #1;
`ifdef DELAY_SLOT_EN
    chk("redir_slot_valid", {31'd0, if_valid}, 32'd1);
    chk("redir_slot_pc4", if_pc4, 32'h28);
`else
    chk("redir_bubble", {31'd0, if_valid}, 32'd0);
`endif
    @(negedge clk); #1;
    chk("redir_target_valid", {31'd0, if_valid}, 32'd1);
    chk("redir_target_pc4", if_pc4, 32'h104);
    wait_drain("drain_redir", 40);

    // Redirect while the 0x24 fetch is still waiting on memory.
    do_reset(2, 1'b0);
    push_range(32'h4, 32'h24);
`ifdef DELAY_SLOT_EN
    exp_q.push_back(32'h28);
`endif
    exp_q.push_back(32'h104);
    wait_pc4(32'h24, 60);
    chk("pend_addr_before", imem_addr, 32'h24);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    begin
      int n = 0;
      #1;
      while (imem_addr == 32'h24 && n < 20) begin
        @(negedge clk); #1;
        n++;
      end
      chk("pend_next_addr", imem_addr, 32'h100);
    end
    wait_drain("drain_pend", 40);

    @(negedge clk);
    sb_active = 1'b0;
    chk("queue_empty_end", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_err);
    $fatal(1);
  end

endmodule
